serial_pattern_gen: RTL and testbench

//  Bit-serial stimulus source for the one-hot sequence-detector FSM: emits a programmed

---
 rtl/serial_pattern_gen_pkg.sv | 15 +
 rtl/serial_pattern_gen_if.sv | 31 +++
 rtl/serial_pattern_gen_pattern_shift_reg.sv | 31 +++
 rtl/serial_pattern_gen.sv | 109 ++++++++++
 tb/tb_serial_pattern_gen.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_pattern_gen_pkg.sv
// Shared definitions for the serial pattern generator and the detector bench.
package serial_pattern_gen_pkg;

  // Default geometry; 2**SPG_CNT_W must exceed SPG_MAX_LEN so len==MAX_LEN fits.
  localparam int SPG_MAX_LEN = 16;
  localparam int SPG_CNT_W   = 5;

  // Generator FSM states, 2-bit binary.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_pattern_gen_if.sv
// Control/stream bundle between the board-side controller and the generator.
interface serial_pattern_gen_if #(
  parameter int MAX_LEN = serial_pattern_gen_pkg::SPG_MAX_LEN,
  parameter int CNT_W   = serial_pattern_gen_pkg::SPG_CNT_W
) ();

  logic               load;
  logic [MAX_LEN-1:0] pattern_in;
  logic [CNT_W-1:0]   len_in;
  logic               start;
  logic               repeat_en;
  logic               stop;
  logic               w_out;
  logic               valid;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   bit_idx;

  // Controller side: drives commands, watches the stream.
  modport master (
    output load, pattern_in, len_in, start, repeat_en, stop,
    input  w_out, valid, busy, done, bit_idx
  );

  // Generator side.
  modport slave (
    input  load, pattern_in, len_in, start, repeat_en, stop,
    output w_out, valid, busy, done, bit_idx
  );

endinterface

// File: rtl/serial_pattern_gen_pattern_shift_reg.sv
// Parallel-load pattern register with a bit-select mux on its output.
// While load_en is high the mux looks at d directly, so a start issued in the
// same cycle as load can already transmit the new pattern's first bit.
module pattern_shift_reg #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_en,
  input  logic [MAX_LEN-1:0] d,
  input  logic [CNT_W-1:0]   idx,
  output logic               bit_o
);

  localparam int EXT_W = 2 ** CNT_W;

  logic [MAX_LEN-1:0] pat_q;
  logic [EXT_W-1:0]   ext;

  // Pattern storage; only written when the FSM grants a load in IDLE.
  always_ff @(posedge clk) begin
    if (reset)        pat_q <= '0;
    else if (load_en) pat_q <= d;
  end

  // Zero-extend to the full index range so any idx value selects a defined bit.
  assign ext   = EXT_W'(load_en ? d : pat_q);
  assign bit_o = ext[idx];

endmodule

// File: rtl/serial_pattern_gen.sv
// Bit-serial stimulus source: shifts a programmed pattern out LSB-first on w_out
// with start/busy/done handshake, optional repeat and stop-through-DONE.
module serial_pattern_gen
  import serial_pattern_gen_pkg::*;
#(
  parameter int MAX_LEN = SPG_MAX_LEN,
  parameter int CNT_W   = SPG_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  serial_pattern_gen_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] len_q, len_d, len_sat;
  logic             w_q, w_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_en;
  logic             pat_bit;
  logic             last_bit;

  assign len_sat  = (bus.len_in > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : bus.len_in;
  assign last_bit = (idx_q == len_q - CNT_W'(1));

  // The mux is addressed with the next index so w_out can be registered.
  pattern_shift_reg #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) u_psr (
    .clk     (clk),
    .reset   (reset),
    .load_en (load_en),
    .d       (bus.pattern_in),
    .idx     (idx_d),
    .bit_o   (pat_bit)
  );

  // FSM state, bit index and stored length.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      w_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      w_q     <= w_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state / index; start sees the length being loaded this same cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    load_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        load_en = bus.load;
        if (bus.load) len_d = len_sat;
        idx_d = '0;
        if (bus.start && (len_d != '0)) state_d = S_SEND;
      end
      S_SEND: begin
        // stop outranks repeat; either way the current bit has completed.
        if (bus.stop || (last_bit && !bus.repeat_en)) begin
          state_d = S_DONE;
          idx_d   = '0;
        end else if (last_bit) begin
          idx_d = '0;
        end else begin
          idx_d = idx_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Registered outputs are derived from the state being entered.
  assign valid_d = (state_d == S_SEND);
  assign w_d     = (state_d == S_SEND) & pat_bit;
  assign done_d  = (state_d == S_DONE);
  assign busy_d  = (state_d != S_IDLE);

  assign bus.w_out   = w_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bit_idx = idx_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Self-checking bench for serial_pattern_gen: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_serial_pattern_gen;
  import serial_pattern_gen_pkg::*;

  localparam int ML = SPG_MAX_LEN;
  localparam int CW = SPG_CNT_W;

  logic clk = 1'b0;
  logic reset = 1'b1;

  serial_pattern_gen_if #(.MAX_LEN(ML), .CNT_W(CW)) bus ();

  serial_pattern_gen #(.MAX_LEN(ML), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic          w;
    logic          valid;
    logic          busy;
    logic          done;
    logic [CW-1:0] idx;
  } obs_t;

  typedef struct {
    logic          load;
    logic [ML-1:0] pat;
    logic [CW-1:0] len;
    logic          start;
    obs_t          exp;
  } vec_t;

  // Reference model: a queue of bit positions still to be shown in this pass.
  logic [ML-1:0] m_pat;
  int            m_len;
  int            m_mode;   // 0 idle, 1 sending, 2 done pulse
  int            m_q[$];
  obs_t          m_exp;

  function automatic obs_t mk(logic w, logic v, logic b, logic d, int idx);
    obs_t o;
    o.w = w; o.valid = v; o.busy = b; o.done = d; o.idx = CW'(idx);
    return o;
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_mode = 0; m_pat = '0; m_len = 0; m_q.delete();
    end else begin
      case (m_mode)
        0: begin
          if (bus.load) begin
            m_pat = bus.pattern_in;
            m_len = (int'(bus.len_in) > ML) ? ML : int'(bus.len_in);
          end
          if (bus.start && m_len > 0) begin
            for (int i = 0; i < m_len; i++) m_q.push_back(i);
            m_mode = 1;
          end
        end
        1: begin
          void'(m_q.pop_front());
          if (bus.stop) begin
            m_q.delete(); m_mode = 2;
          end else if (m_q.size() == 0) begin
            if (bus.repeat_en) for (int i = 0; i < m_len; i++) m_q.push_back(i);
            else m_mode = 2;
          end
        end
        default: m_mode = 0;
      endcase
    end
    if (m_mode == 1)      m_exp = mk(m_pat[m_q[0]], 1'b1, 1'b1, 1'b0, m_q[0]);
    else if (m_mode == 2) m_exp = mk(1'b0, 1'b0, 1'b1, 1'b1, 0);
    else                  m_exp = mk(1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic check_obs(string name, obs_t exp);
    obs_t act;
    act = mk(bus.w_out, bus.valid, bus.busy, bus.done, int'(bus.bit_idx));
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t: got w=%b valid=%b busy=%b done=%b idx=%0d, want w=%b valid=%b busy=%b done=%b idx=%0d",
               name, $time, act.w, act.valid, act.busy, act.done, act.idx,
               exp.w, exp.valid, exp.busy, exp.done, exp.idx);
    end
  endtask

  task automatic check_int(string name, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // One clock: model follows the edge, DUT is compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_obs("model", m_exp);
  endtask

  task automatic clr_in();
    bus.load = 1'b0; bus.pattern_in = '0; bus.len_in = '0;
    bus.start = 1'b0; bus.repeat_en = 1'b0; bus.stop = 1'b0;
  endtask

  task automatic load_start(logic [ML-1:0] p, int len, logic rep);
    bus.load = 1'b1; bus.pattern_in = p; bus.len_in = CW'(len);
    bus.start = 1'b1; bus.repeat_en = rep;
    cyc();
    bus.load = 1'b0; bus.start = 1'b0;
  endtask

  // Advance until the model shows bit position idx; bounded.
  task automatic wait_idx(int idx, string name);
    int k;
    k = 0;
    while (!(m_exp.valid && int'(m_exp.idx) == idx) && k < 40) begin
      cyc(); k++;
    end
    check_int(name, (m_exp.valid && int'(m_exp.idx) == idx) ? 1 : 0, 1);
  endtask

  // Run until idle, counting valid bits and done pulses seen on the DUT.
  task automatic drain(output int nv, output int nd);
    nv = 0; nd = 0;
    for (int k = 0; k < 60; k++) begin
      cyc();
      nv += int'(bus.valid);
      nd += int'(bus.done);
      if (!bus.busy && m_mode == 0) break;
    end
  endtask

  vec_t tbl[11];
  int   nv, nd;

  initial begin
    m_pat = '0; m_len = 0; m_mode = 0; m_exp = '0;
    clr_in();

    // Vector table: basic transmission, then load+start in one cycle.
    tbl[0]  = '{1'b1, 16'h000B, 5'd4, 1'b0, mk(0, 0, 0, 0, 0)};
    tbl[1]  = '{1'b0, 16'h0000, 5'd0, 1'b1, mk(1, 1, 1, 0, 0)};
    tbl[2]  = '{1'b0, 16'h0000, 5'd0, 1'b0, mk(1, 1, 1, 0, 1)};
    tbl[3]  = '{1'b0, 16'h0000, 5'd0, 1'b0, mk(0, 1, 1, 0, 2)};
    tbl[4]  = '{1'b0, 16'h0000, 5'd0, 1'b0, mk(1, 1, 1, 0, 3)};
    tbl[5]  = '{1'b0, 16'h0000, 5'd0, 1'b0, mk(0, 0, 1, 1, 0)};
    tbl[6]  = '{1'b0, 16'h0000, 5'd0, 1'b0, mk(0, 0, 0, 0, 0)};
    tbl[7]  = '{1'b1, 16'h0006, 5'd2, 1'b1, mk(0, 1, 1, 0, 0)};
    tbl[8]  = '{1'b0, 16'h0000, 5'd0, 1'b0, mk(1, 1, 1, 0, 1)};
    tbl[9]  = '{1'b0, 16'h0000, 5'd0, 1'b0, mk(0, 0, 1, 1, 0)};
    tbl[10] = '{1'b0, 16'h0000, 5'd0, 1'b0, mk(0, 0, 0, 0, 0)};

    // Reset held two cycles: everything zero.
    reset = 1'b1;
    cyc(); cyc();
    check_obs("reset", mk(0, 0, 0, 0, 0));
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      bus.load = tbl[i].load; bus.pattern_in = tbl[i].pat;
      bus.len_in = tbl[i].len; bus.start = tbl[i].start;
      cyc();
      check_obs($sformatf("table[%0d]", i), tbl[i].exp);
    end
    clr_in();

    // Repeat with no gap; repeat dropped during the third pass.
    nv = 0; nd = 0;
    load_start(16'h000B, 4, 1'b1);
    nv += int'(bus.valid);
    for (int k = 0; k < 10; k++) begin
      cyc(); nv += int'(bus.valid); nd += int'(bus.done);
    end
    bus.repeat_en = 1'b0;
    begin
      int v2, d2;
      drain(v2, d2);
      nv += v2; nd += d2;
    end
    check_int("repeat_bits", nv, 12);
    check_int("repeat_done", nd, 1);

    // Reset at bit 2 of an 8-bit transmission: no done afterwards.
    load_start(16'h00A5, 8, 1'b0);
    wait_idx(2, "reach_bit2");
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_obs("midreset", mk(0, 0, 0, 0, 0));
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      cyc(); nd += int'(bus.done) + int'(bus.busy);
    end
    check_int("midreset_quiet", nd, 0);

    // Zero length: start ignored.
    bus.load = 1'b1; bus.len_in = '0; bus.pattern_in = 16'hFFFF;
    cyc();
    bus.load = 1'b0; bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    nd = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(); nd += int'(bus.busy) + int'(bus.done);
    end
    check_int("len0_ignored", nd, 0);

    // Oversized length saturates to MAX_LEN.
    load_start(16'h9C3B, 20, 1'b0);
    drain(nv, nd);
    check_int("len20_bits", nv + 1, ML);
    check_int("len20_done", nd, 1);

    // Load/start while busy are ignored.
    load_start(16'h002D, 6, 1'b0);
    cyc();
    bus.load = 1'b1; bus.pattern_in = 16'hFFFF; bus.len_in = 5'd3; bus.start = 1'b1;
    cyc();
    clr_in();
    drain(nv, nd);
    check_int("busy_ignore_bits", nv + 3, 6);

    // Stop at bit 1 of 6: bit 1 completes, then done.
    load_start(16'h002D, 6, 1'b1);
    wait_idx(1, "reach_bit1");
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    check_obs("stop_done", mk(0, 0, 1, 1, 0));
    cyc();
    check_obs("stop_idle", mk(0, 0, 0, 0, 0));

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      reset          = ($urandom_range(0, 99) == 0);
      bus.load       = ($urandom_range(0, 7) == 0);
      bus.start      = ($urandom_range(0, 5) == 0);
      bus.stop       = ($urandom_range(0, 19) == 0);
      bus.repeat_en  = $urandom_range(0, 1);
      bus.len_in     = CW'($urandom_range(0, 31));
      bus.pattern_in = ML'($urandom);
      cyc();
    end
    reset = 1'b0;
    clr_in();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
